booth_sequential_multiplier: RTL and testbench

BOOTH_SEQUENTIAL_MULTIPLIER -- requirements
Module: booth_sequential_multiplier

---
 rtl/booth_sequential_multiplier.sv | 149 ++++++++++++++
 tb/tb_booth_sequential_multiplier.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_sequential_multiplier.sv
// rtl/booth_sequential_multiplier.sv - radix-2 Booth sequential signed multiplier
//
// Purpose: multiplies two WIDTH-bit two's-complement operands, one Booth step
// per clock, producing a 2*WIDTH-bit two's-complement product.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a multiplication (accepted only while ready=1)
//   multiplicand  in   WIDTH  operand M, sampled on the accept edge
//   multiplier    in   WIDTH  operand Q, sampled on the accept edge
//   ready         out  high while idle
//   done          out  one-cycle completion pulse
//   product       out  2*WIDTH  registered result, held until the next completion

module booth_sequential_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_m;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_m1;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_a_sum;
  logic [WIDTH:0]     w_a_next;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_q_m1_next;
  logic               w_last;
  logic               w_ready;
  logic               w_done;

  // One extra accumulator bit keeps A - (most negative M) representable.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_last  = (r_count == CNT_ONE);

  // Booth step: add/subtract on {Q[0],Q_-1}, then arithmetic shift {A,Q,Q_-1}.
  always_comb begin
    w_a_sum = r_a;
    case ({r_q[0], r_q_m1})
      2'b01:   w_a_sum = r_a + w_m_ext;
      2'b10:   w_a_sum = r_a - w_m_ext;
      default: w_a_sum = r_a;
    endcase
    w_a_next    = {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
    w_q_next    = {w_a_sum[0], r_q[WIDTH-1:1]};
    w_q_m1_next = r_q[0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
      S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_DONE:  w_done  = 1'b1;
      default: begin
        w_ready = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_a     <= '0;
            r_q     <= multiplier;
            r_q_m1  <= 1'b0;
            r_count <= CNT_INIT;
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_q_m1  <= w_q_m1_next;
          r_count <= r_count - CNT_ONE;
          // Capture the final shifted value on the same edge that enters DONE.
          if (w_last) begin
            r_product <= {w_a_next[WIDTH-1:0], w_q_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready   = w_ready;
  assign done    = w_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// tb/tb_booth_sequential_multiplier.sv - self-checking bench for booth_sequential_multiplier

module tb_booth_sequential_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  booth_sequential_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] r;
    r = $signed(m) * $signed(q);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one multiplication from IDLE; returns product at done, edges from
  // accept to done, and how many cycles ready was seen high meanwhile.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [2*W-1:0] p, output int lat, output int ready_hi);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lat = 0;
    ready_hi = 0;
    p = '0;
    while (lat < 40) begin
      if (ready) ready_hi++;
      step();
      lat++;
      if (done) break;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b done=%b product=%h, need ready=1 done=0 product=0000", ready, done, product);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: ready=%b done=%b, need 1/0", ready, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]   vm [6] = '{8'h03, 8'hFD, 8'h00, 8'h80, 8'h7F, 8'h80};
    logic [W-1:0]   vq [6] = '{8'h05, 8'h05, 8'hF9, 8'h80, 8'h80, 8'h7F};
    logic [2*W-1:0] vp [6] = '{16'h000F, 16'hFFF1, 16'h0000, 16'h4000, 16'hC080, 16'hC080};
    logic [2*W-1:0] p;
    logic [2*W-1:0] held;
    int lat, rh;
    for (int i = 0; i < 6; i++) begin
      run_op(vm[i], vq[i], p, lat, rh);
      n_cmp++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: edges=%0d need %0d", i, lat, W);
      end
      n_cmp++;
      if (p !== vp[i]) begin
        n_err++;
        $display("FAIL directed_product[%0d]: got %h need %h", i, p, vp[i]);
      end
      n_cmp++;
      if (rh !== 0) begin
        n_err++;
        $display("FAIL directed_ready_low[%0d]: ready high %0d cycles, need 0", i, rh);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed_done_pulse[%0d]: done=%b ready=%b one edge later, need 0/1", i, done, ready);
      end
    end
    held = product;
    for (int i = 0; i < 5; i++) begin
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      step();
    end
    n_cmp++;
    if (product !== 16'hC080 || ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: product=%h ready=%b done=%b, need C080/1/0 (was %h)", product, ready, done, held);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m, q;
    logic [2*W-1:0] p, e;
    int lat, rh;
    for (int i = 0; i < 40; i++) begin
      m = W'($urandom);
      q = W'($urandom);
      if (i == 0) begin m = 8'h80; q = 8'h01; end
      if (i == 1) begin m = 8'hFF; q = 8'hFF; end
      e = ref_mul(m, q);
      run_op(m, q, p, lat, rh);
      n_cmp++;
      if (p !== e || lat !== W) begin
        n_err++;
        $display("FAIL random[%0d] %h*%h: got %h after %0d edges, need %h after %0d", i, m, q, p, lat, e, W);
      end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    multiplicand = 8'd6;
    multiplier   = 8'd7;
    start        = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        multiplicand = 8'd9;
        multiplier   = 8'd11;
        start        = 1'b1;
      end
      if (i == 3) start = 1'b0;
      step();
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL ignore_start_pulses: %0d done pulses, need 1", ndone);
    end
    n_cmp++;
    if (product !== 16'h002A) begin
      n_err++;
      $display("FAIL ignore_start_product: got %h need 002A", product);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] p;
    int lat, rh, ndone;
    multiplicand = 8'h55;
    multiplier   = 8'h33;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (product !== '0 || ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: product=%h ready=%b done=%b, need 0000/1/0", product, ready, done);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0 || ready !== 1'b1 || product !== '0) begin
      n_err++;
      $display("FAIL reset_abort: done pulses=%0d ready=%b product=%h, need 0/1/0000", ndone, ready, product);
    end
    run_op(8'd2, 8'hFE, p, lat, rh);
    n_cmp++;
    if (p !== 16'hFFFC || lat !== W) begin
      n_err++;
      $display("FAIL after_reset_op: got %h after %0d edges, need FFFC after %0d", p, lat, W);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int rdy_cnt, bad_prod, bad_gap, bad_rdy;
    multiplicand = 8'd1;
    multiplier   = 8'd1;
    start        = 1'b1;
    rdy_cnt = 0;
    bad_prod = 0;
    bad_rdy = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (done) begin
        done_cyc.push_back(c);
        if (product !== 16'h0001) bad_prod++;
      end
      if (ready) begin
        rdy_cnt++;
        if (c % 10 != 0) bad_rdy++;
      end
    end
    start = 1'b0;
    bad_gap = 0;
    for (int i = 1; i < done_cyc.size(); i++)
      if (done_cyc[i] - done_cyc[i-1] != 10) bad_gap++;
    n_cmp++;
    if (done_cyc.size() !== 3 || bad_gap !== 0) begin
      n_err++;
      $display("FAIL b2b_pulses: %0d pulses with %0d bad gaps, need 3 pulses every 10 cycles", done_cyc.size(), bad_gap);
    end
    n_cmp++;
    if (done_cyc.size() > 0 && done_cyc[0] !== W + 1) begin
      n_err++;
      $display("FAIL b2b_first_done: cycle %0d need %0d", done_cyc[0], W + 1);
    end
    n_cmp++;
    if (bad_prod !== 0) begin
      n_err++;
      $display("FAIL b2b_product: %0d pulses with product != 0001, need 0", bad_prod);
    end
    n_cmp++;
    if (rdy_cnt !== 3 || bad_rdy !== 0) begin
      n_err++;
      $display("FAIL b2b_ready: ready high %0d cycles (%0d misplaced), need 3 (0)", rdy_cnt, bad_rdy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
